bounce_gen: RTL and testbench

//   Transmit-side counterpart of the button debouncer: converts a clean press/release

---
 rtl/bounce_gen_if.sv | 34 +++
 rtl/bounce_gen.sv | 209 ++++++++++++++++++++
 tb/tb_bounce_gen.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bounce_gen_if.sv
// ---------------------------------------------------------------------------
// bounce_gen_if
//   Request/response bundle for the bounce_gen button-waveform generator.
//   master : issues requests (req_valid, req_ch, req_level, bounce_cnt,
//            half_period) and observes req_ready, btn_out, busy, done.
//   slave  : the generator itself (the inverse direction of every signal).
// ---------------------------------------------------------------------------
interface bounce_gen_if #(
    parameter int NUM_CH = 4,
    parameter int HP_W   = 8,
    parameter int BC_W   = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [CH_W-1:0]   req_ch;
    logic              req_level;
    logic [BC_W-1:0]   bounce_cnt;
    logic [HP_W-1:0]   half_period;
    logic [NUM_CH-1:0] btn_out;
    logic              busy;
    logic              done;

    modport master (
        output req_valid, req_ch, req_level, bounce_cnt, half_period,
        input  req_ready, btn_out, busy, done
    );

    modport slave (
        input  req_valid, req_ch, req_level, bounce_cnt, half_period,
        output req_ready, btn_out, busy, done
    );
endinterface

// File: rtl/bounce_gen.sv
// ---------------------------------------------------------------------------
// bounce_gen
//   Turns a clean press/release request into a bouncy waveform on one of
//   NUM_CH button lines: B pairs of (level for H cycles, ~level for H cycles),
//   then level held for SETTLE_CYC cycles, then a one-cycle done pulse.
//
// Ports
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : bounce_gen_if.slave
//          req_valid/req_ready handshake, req_ch, req_level, bounce_cnt (B),
//          half_period (H, 0 treated as 1), btn_out lines, busy, done pulse.
//
// Configuration macro
//   BOUNCE_JITTER_EN : when defined, each bounce phase is stretched by 0..3
//                      cycles taken from a free-running 16-bit LFSR.
//
// All outputs are registered from the current state, so every output lags
// the FSM state by one cycle; the accept edge N therefore shows on btn_out
// from edge N+1 onwards.
// ---------------------------------------------------------------------------
module bounce_gen #(
    parameter int NUM_CH     = 4,
    parameter int HP_W       = 8,
    parameter int BC_W       = 4,
    parameter int SETTLE_CYC = 16
) (
    input  logic         clk,
    input  logic         rst,
    bounce_gen_if.slave  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PH_W = HP_W + 2;
    localparam logic [PH_W-1:0] SETTLE_LOAD = PH_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_HI,
        S_BOUNCE_LO,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [BC_W-1:0]   pair_cnt_q, pair_cnt_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              level_q, level_d;
    logic [NUM_CH-1:0] btn_q, btn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic              accept;
    logic [HP_W-1:0]   h_in;
    logic [1:0]        jitter;
    logic [BC_W-1:0]   pair_inc;
    logic              drive_en;
    logic              drive_val;

`ifdef BOUNCE_JITTER_EN
    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, free-running.
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign jitter = lfsr_q[1:0];
`else
    assign jitter = 2'b00;
`endif

    // Counter preload for a bounce phase: the phase lasts (load + 1) cycles.
    function automatic logic [PH_W-1:0] phase_load(input logic [HP_W-1:0] h,
                                                   input logic [1:0]      j);
        return {2'b00, h} - PH_W'(1) + {{(PH_W-2){1'b0}}, j};
    endfunction

    // ready_q is only ever set while the FSM sits in IDLE, so it alone
    // qualifies the handshake.
    assign accept   = bus.req_valid && ready_q;
    assign h_in     = (bus.half_period == '0) ? HP_W'(1) : bus.half_period;
    assign pair_inc = pair_cnt_q + BC_W'(1);

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        pair_cnt_d  = pair_cnt_q;
        bc_d        = bc_q;
        hp_d        = hp_q;
        ch_d        = ch_q;
        level_d     = level_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ch_d       = bus.req_ch;
                    level_d    = bus.req_level;
                    bc_d       = bus.bounce_cnt;
                    hp_d       = h_in;
                    pair_cnt_d = '0;
                    if (bus.bounce_cnt == '0) begin
                        state_d     = S_SETTLE;
                        phase_cnt_d = SETTLE_LOAD;
                    end else begin
                        state_d     = S_BOUNCE_HI;
                        phase_cnt_d = phase_load(h_in, jitter);
                    end
                end
            end
            S_BOUNCE_HI: begin
                if (phase_cnt_q == '0) begin
                    state_d     = S_BOUNCE_LO;
                    phase_cnt_d = phase_load(hp_q, jitter);
                end else begin
                    phase_cnt_d = phase_cnt_q - PH_W'(1);
                end
            end
            S_BOUNCE_LO: begin
                if (phase_cnt_q == '0) begin
                    pair_cnt_d = pair_inc;
                    if (pair_inc < bc_q) begin
                        state_d     = S_BOUNCE_HI;
                        phase_cnt_d = phase_load(hp_q, jitter);
                    end else begin
                        state_d     = S_SETTLE;
                        phase_cnt_d = SETTLE_LOAD;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q - PH_W'(1);
                end
            end
            S_SETTLE: begin
                if (phase_cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    phase_cnt_d = phase_cnt_q - PH_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next-values derived from the current state.
    always_comb begin
        drive_en  = (state_q != S_IDLE);
        drive_val = (state_q == S_BOUNCE_LO) ? ~level_q : level_q;
        busy_d    = (state_q == S_BOUNCE_HI) || (state_q == S_BOUNCE_LO) ||
                    (state_q == S_SETTLE);
        done_d    = (state_q == S_DONE);
        ready_d   = (state_q == S_IDLE) && !accept;
    end

    // An out-of-range channel index matches no line, so nothing moves.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_line
            assign btn_d[gi] = (drive_en && (ch_q == CH_W'(gi))) ? drive_val : btn_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_cnt_q <= '0;
            pair_cnt_q  <= '0;
            bc_q        <= '0;
            hp_q        <= '0;
            ch_q        <= '0;
            level_q     <= 1'b0;
            btn_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            pair_cnt_q  <= pair_cnt_d;
            bc_q        <= bc_d;
            hp_q        <= hp_d;
            ch_q        <= ch_d;
            level_q     <= level_d;
            btn_q       <= btn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.btn_out   = btn_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bounce_gen.sv
// ---------------------------------------------------------------------------
// tb_bounce_gen
//   Self-checking bench for bounce_gen (default build, no jitter).
//   Each request pushes the expected per-cycle btn_out/done/busy/req_ready
//   values from the accept cycle to the done cycle onto a queue, which is
//   then popped and compared once per clock.
// ---------------------------------------------------------------------------
module tb_bounce_gen;
    localparam int NUM_CH = 4;
    localparam int HP_W   = 8;
    localparam int BC_W   = 4;
    localparam int SETTLE = 16;

    typedef struct {
        logic [NUM_CH-1:0] btn;
        logic              done;
        logic              busy;
        logic              ready;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [NUM_CH-1:0] exp_btn;
    exp_t sb[$];

    bounce_gen_if #(.NUM_CH(NUM_CH), .HP_W(HP_W), .BC_W(BC_W)) bus ();

    bounce_gen #(
        .NUM_CH(NUM_CH), .HP_W(HP_W), .BC_W(BC_W), .SETTLE_CYC(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for req_ready, then present a request; the next edge accepts it.
    task automatic issue(input int ch, input logic lvl, input int b, input int h,
                         output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ready_wait: req_ready=%b, required 1 within 64 cycles", bus.req_ready);
        end else begin
            bus.req_ch      = 2'(ch);
            bus.req_level   = lvl;
            bus.bounce_cnt  = 4'(b);
            bus.half_period = 8'(h);
            bus.req_valid   = 1'b1;
        end
    endtask

    // Called just before the accept edge. Builds the expected waveform and checks it.
    task automatic run_seq(input int ch, input logic lvl, input int b, input int h,
                           input bit has_next, input int nch, input logic nlvl,
                           input int nb, input int nh);
        int heff;
        int cyc;
        exp_t e;
        logic [NUM_CH-1:0] cur;
        heff = (h == 0) ? 1 : h;
        cur  = exp_btn;
        // accept cycle: outputs not yet moved
        e.btn = cur; e.done = 1'b0; e.busy = 1'b0; e.ready = 1'b0;
        sb.push_back(e);
        for (int p = 0; p < b; p++) begin
            for (int k = 0; k < heff; k++) begin
                cur[ch] = lvl;
                e.btn = cur; e.done = 1'b0; e.busy = 1'b1; e.ready = 1'b0;
                sb.push_back(e);
            end
            for (int k = 0; k < heff; k++) begin
                cur[ch] = ~lvl;
                e.btn = cur; e.done = 1'b0; e.busy = 1'b1; e.ready = 1'b0;
                sb.push_back(e);
            end
        end
        for (int k = 0; k < SETTLE; k++) begin
            cur[ch] = lvl;
            e.btn = cur; e.done = 1'b0; e.busy = 1'b1; e.ready = 1'b0;
            sb.push_back(e);
        end
        e.btn = cur; e.done = 1'b1; e.busy = 1'b0; e.ready = 1'b0;
        sb.push_back(e);
        exp_btn = cur;

        step();  // accept edge passed; fields may change freely from here on
        if (has_next) begin
            bus.req_ch      = 2'(nch);
            bus.req_level   = nlvl;
            bus.bounce_cnt  = 4'(nb);
            bus.half_period = 8'(nh);
        end else begin
            bus.req_valid   = 1'b0;
            bus.req_ch      = 2'($urandom_range(0, 3));
            bus.req_level   = ~lvl;
            bus.bounce_cnt  = 4'($urandom_range(0, 15));
            bus.half_period = 8'($urandom_range(0, 255));
        end

        cyc = 0;
        while (sb.size() > 0) begin
            if (cyc > 0) step();
            e = sb.pop_front();
            checks++;
            if (bus.btn_out !== e.btn) begin
                errors++;
                $display("FAIL btn_out ch=%0d cyc=%0d: got %b, required %b", ch, cyc, bus.btn_out, e.btn);
            end
            checks++;
            if (bus.done !== e.done) begin
                errors++;
                $display("FAIL done ch=%0d cyc=%0d: got %b, required %b", ch, cyc, bus.done, e.done);
            end
            checks++;
            if (bus.busy !== e.busy) begin
                errors++;
                $display("FAIL busy ch=%0d cyc=%0d: got %b, required %b", ch, cyc, bus.busy, e.busy);
            end
            checks++;
            if (bus.req_ready !== e.ready) begin
                errors++;
                $display("FAIL req_ready ch=%0d cyc=%0d: got %b, required %b", ch, cyc, bus.req_ready, e.ready);
            end
            cyc++;
        end
        step();  // cycle after done
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_done ch=%0d: got %b, required 1", ch, bus.req_ready);
        end
        $display("txn ch=%0d level=%b B=%0d H=%0d done_cycle=N+%0d btn_out=%b",
                 ch, lvl, b, h, cyc - 1, bus.btn_out);
    endtask

    task automatic single(input int ch, input logic lvl, input int b, input int h);
        bit ok;
        issue(ch, lvl, b, h, ok);
        if (ok) run_seq(ch, lvl, b, h, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.btn_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: btn=%b busy=%b done=%b ready=%b, required 0000 0 0 0",
                         bus.btn_out, bus.busy, bus.done, bus.req_ready);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", bus.req_ready);
        end
        exp_btn = '0;
        $display("txn reset btn_out=%b ready=%b", bus.btn_out, bus.req_ready);
    endtask

    task automatic test_bounce();
        single(0, 1'b1, 3, 2);          // done at N+29
    endtask

    task automatic test_no_bounce();
        single(2, 1'b1, 0, 5);          // done at N+17
    endtask

    task automatic test_zero_half_period();
        single(1, 1'b1, 2, 0);          // 1-cycle phases, done at N+21
    endtask

    task automatic test_same_level();
        single(2, 1'b1, 1, 1);          // line already 1: bounce on hold
        single(0, 1'b0, 2, 3);          // release with bounce
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit saw_done;
        issue(0, 1'b1, 4, 3, ok);
        if (ok) begin
            step();                     // cycle N
            bus.req_valid = 1'b0;
            for (int i = 0; i < 4; i++) step();   // cycle N+4: inside the low phase
            checks++;
            if (bus.btn_out[0] !== 1'b0) begin
                errors++;
                $display("FAIL mid_low_phase: btn_out[0]=%b, required 0", bus.btn_out[0]);
            end
            rst = 1'b1;
            step();
            checks++;
            if (bus.btn_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_state: btn=%b busy=%b done=%b ready=%b, required 0000 0 0 0",
                         bus.btn_out, bus.busy, bus.done, bus.req_ready);
            end
            rst = 1'b0;
            exp_btn = '0;
            saw_done = 1'b0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (bus.done === 1'b1) saw_done = 1'b1;
            end
            checks++;
            if (saw_done) begin
                errors++;
                $display("FAIL mid_reset_no_done: done pulsed, required none");
            end
            $display("txn mid-sequence reset btn_out=%b done_seen=%b", bus.btn_out, saw_done);
            single(0, 1'b1, 1, 1);
        end
    endtask

    // valid held through DONE; fields switch to the second request right after
    // the first accept, which must not disturb the first sequence.
    task automatic test_back_to_back();
        bit ok;
        issue(3, 1'b1, 2, 2, ok);
        if (ok) begin
            run_seq(3, 1'b1, 2, 2, 1'b1, 1, 1'b0, 1, 4);
            run_seq(1, 1'b0, 1, 4, 1'b0, 0, 1'b0, 0, 0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            single(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
        end
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        exp_btn         = '0;
        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_ch      = '0;
        bus.req_level   = 1'b0;
        bus.bounce_cnt  = '0;
        bus.half_period = '0;
        test_reset();
        test_bounce();
        test_no_bounce();
        test_zero_half_period();
        test_same_level();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
